// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: control-bit positions, field widths and the
// MEM/WB register layout used by the memory stage.
package pipeline_pkg;

  localparam int unsigned WB_REG_WRITE  = 0;
  localparam int unsigned WB_MEM_TO_REG = 1;
  localparam int unsigned M_MEM_WRITE   = 0;
  localparam int unsigned M_MEM_READ    = 1;
  localparam int unsigned M_BRANCH      = 2;

  localparam int unsigned WB_CTL_W   = 2;
  localparam int unsigned M_CTL_W    = 3;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef struct packed {
    logic [WB_CTL_W-1:0]   wb_ctl;
    logic [DATA_W-1:0]     alu_result;
    logic [REG_ADDR_W-1:0] reg_dst;
  } mem_wb_t;

  localparam mem_wb_t MEM_WB_BUBBLE = '{
    wb_ctl:     {WB_CTL_W{1'b0}},
    alu_result: {DATA_W{1'b0}},
    reg_dst:    {REG_ADDR_W{1'b0}}
  };

endpackage

// File: rtl/mem_stage_data_memory.sv
// Single-port data memory with synchronous write and a read-first output
// register; the caller decides when that register samples, holds or clears.
module data_memory
  import pipeline_pkg::*;
#(
  parameter int DMEM_DEPTH = 256,
  parameter int ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic              rd_en,
  input  logic              clr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  // Contents start at zero and survive reset.
  logic [DATA_W-1:0] mem_r [DMEM_DEPTH] = '{default: {DATA_W{1'b0}}};

  // Storage write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

  // Output register: non-blocking read of mem_r gives read-first behaviour.
  always_ff @(posedge clk) begin
    if (clr) begin
      rdata <= {DATA_W{1'b0}};
    end else if (rd_en) begin
      rdata <= mem_r[addr];
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: data-memory access, branch resolution and the MEM/WB
// pipeline register with reset > flush > stall > normal priority.
module mem_stage
  import pipeline_pkg::*;
#(
  parameter int DMEM_DEPTH = 256,
  parameter int ADDR_W     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [WB_CTL_W-1:0]   ex_mem_wb_ctl,
  input  logic [M_CTL_W-1:0]    ex_mem_m_ctl,
  input  logic [DATA_W-1:0]     ex_mem_alu_result,
  input  logic                  ex_mem_zero,
  input  logic [DATA_W-1:0]     ex_mem_write_data,
  input  logic [REG_ADDR_W-1:0] ex_mem_mux_reg_dst,
  input  logic [DATA_W-1:0]     ex_mem_branch_target,
  output logic                  mem_pc_src,
  output logic [DATA_W-1:0]     mem_branch_target,
  output logic [WB_CTL_W-1:0]   mem_wb_wb_ctl,
  output logic [DATA_W-1:0]     mem_wb_alu_result,
  output logic [DATA_W-1:0]     mem_wb_read_data,
  output logic [REG_ADDR_W-1:0] mem_wb_mux_reg_dst
);

  logic              mem_write_s;
  logic              mem_read_s;
  logic              branch_s;
  logic              dmem_we_s;
  logic              dmem_rd_en_s;
  logic              dmem_clr_s;
  logic [ADDR_W-1:0] word_addr_s;
  mem_wb_t           mem_wb_r;

  // Control decode and memory-port gating.
  always_comb begin
    mem_write_s  = ex_mem_m_ctl[M_MEM_WRITE];
    mem_read_s   = ex_mem_m_ctl[M_MEM_READ];
    branch_s     = ex_mem_m_ctl[M_BRANCH];
    word_addr_s  = ex_mem_alu_result[ADDR_W+1:2];
    dmem_we_s    = mem_write_s & ~stall & ~flush & ~reset;
    dmem_rd_en_s = ~stall;
    // A non-stalled cycle without MemRead must present zero load data.
    dmem_clr_s   = reset | flush | (~stall & ~mem_read_s);
  end

  data_memory #(
    .DMEM_DEPTH (DMEM_DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_dmem (
    .clk   (clk),
    .we    (dmem_we_s),
    .rd_en (dmem_rd_en_s),
    .clr   (dmem_clr_s),
    .addr  (word_addr_s),
    .wdata (ex_mem_write_data),
    .rdata (mem_wb_read_data)
  );

  // MEM/WB register for the non-memory fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_wb_r <= MEM_WB_BUBBLE;
    end else if (flush) begin
      mem_wb_r <= MEM_WB_BUBBLE;
    end else if (stall) begin
      mem_wb_r <= mem_wb_r;
    end else begin
      mem_wb_r.wb_ctl     <= ex_mem_wb_ctl;
      mem_wb_r.alu_result <= ex_mem_alu_result;
      mem_wb_r.reg_dst    <= ex_mem_mux_reg_dst;
    end
  end

  assign mem_wb_wb_ctl      = mem_wb_r.wb_ctl;
  assign mem_wb_alu_result  = mem_wb_r.alu_result;
  assign mem_wb_mux_reg_dst = mem_wb_r.reg_dst;

  assign mem_pc_src        = branch_s & ex_mem_zero & ~flush & ~reset;
  assign mem_branch_target = ex_mem_branch_target;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed scenarios followed by random traffic
// checked against a word-array reference model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, zero;
  logic [1:0]  wb_ctl;
  logic [2:0]  m_ctl;
  logic [31:0] alu_result, write_data, branch_target_in;
  logic [4:0]  reg_dst;
  logic        pc_src;
  logic [31:0] branch_target_out;
  logic [1:0]  o_wb_ctl;
  logic [31:0] o_alu_result, o_read_data;
  logic [4:0]  o_reg_dst;

  typedef struct {
    logic [1:0]  wb_ctl;
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic [4:0]  reg_dst;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        model_wb;
  logic [31:0] model_mem [256];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mem_stage #(.DMEM_DEPTH(256), .ADDR_W(8)) dut (
    .clk                  (clk),
    .reset                (reset),
    .stall                (stall),
    .flush                (flush),
    .ex_mem_wb_ctl        (wb_ctl),
    .ex_mem_m_ctl         (m_ctl),
    .ex_mem_alu_result    (alu_result),
    .ex_mem_zero          (zero),
    .ex_mem_write_data    (write_data),
    .ex_mem_mux_reg_dst   (reg_dst),
    .ex_mem_branch_target (branch_target_in),
    .mem_pc_src           (pc_src),
    .mem_branch_target    (branch_target_out),
    .mem_wb_wb_ctl        (o_wb_ctl),
    .mem_wb_alu_result    (o_alu_result),
    .mem_wb_read_data     (o_read_data),
    .mem_wb_mux_reg_dst   (o_reg_dst)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one EX/MEM cycle at the falling edge, check the combinational
  // outputs, then advance the model and queue what MEM/WB must show after the edge.
  task automatic step(input logic r, input logic st, input logic fl, input logic [1:0] wb,
                      input logic [2:0] m, input logic [31:0] addr, input logic z,
                      input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] tgt);
    int idx;
    reset = r; stall = st; flush = fl; wb_ctl = wb; m_ctl = m; alu_result = addr;
    zero = z; write_data = wd; reg_dst = rd; branch_target_in = tgt;
    #1;
    check("pc_src", {31'd0, pc_src}, {31'd0, m[2] && z && !fl && !r});
    check("branch_target", branch_target_out, tgt);
    idx = (addr / 4) % 256;
    if (r || fl) begin
      model_wb = '{2'd0, 32'd0, 32'd0, 5'd0};
    end else if (!st) begin
      model_wb.wb_ctl     = wb;
      model_wb.alu_result = addr;
      model_wb.reg_dst    = rd;
      model_wb.read_data  = m[1] ? model_mem[idx] : 32'd0;
    end
    if (m[0] && !st && !fl && !r) model_mem[idx] = wd;
    exp_q.push_back(model_wb);
    @(negedge clk);
  endtask

  // Monitor: after each rising edge, compare MEM/WB against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wb_ctl", {30'd0, o_wb_ctl}, {30'd0, e.wb_ctl});
        check("alu_result", o_alu_result, e.alu_result);
        check("read_data", o_read_data, e.read_data);
        check("reg_dst", {27'd0, o_reg_dst}, {27'd0, e.reg_dst});
      end
    end
  end

  initial begin
    logic [2:0] rm;
    for (int i = 0; i < 256; i++) model_mem[i] = 32'd0;
    model_wb = '{2'd0, 32'd0, 32'd0, 5'd0};
    reset = 1'b0; stall = 1'b0; flush = 1'b0; wb_ctl = 2'd0; m_ctl = 3'd0;
    alu_result = 32'd0; zero = 1'b0; write_data = 32'd0; reg_dst = 5'd0;
    branch_target_in = 32'd0;
    @(negedge clk);

    // Reset with a pending store to word 4, then read word 4 back.
    step(1'b1, 1'b0, 1'b0, 2'b11, 3'b001, 32'h10, 1'b0, 32'hCAFE_F00D, 5'd3, 32'h0);
    step(1'b1, 1'b0, 1'b0, 2'b11, 3'b101, 32'h10, 1'b1, 32'hCAFE_F00D, 5'd3, 32'h80);
    step(1'b0, 1'b0, 1'b0, 2'b11, 3'b010, 32'h10, 1'b0, 32'h0, 5'd4, 32'h0);
    // Store then load.
    step(1'b0, 1'b0, 1'b0, 2'b00, 3'b001, 32'h20, 1'b0, 32'hDEAD_BEEF, 5'd0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 2'b11, 3'b010, 32'h20, 1'b0, 32'h0, 5'd8, 32'h0);
    // Address wrap and ignored low bits.
    step(1'b0, 1'b0, 1'b0, 2'b00, 3'b001, 32'h400, 1'b0, 32'h1234_5678, 5'd0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 2'b11, 3'b010, 32'h003, 1'b0, 32'h0, 5'd9, 32'h0);
    // Branch taken, not taken, flushed.
    step(1'b0, 1'b0, 1'b0, 2'b00, 3'b100, 32'h0, 1'b1, 32'h0, 5'd0, 32'h40);
    step(1'b0, 1'b0, 1'b0, 2'b00, 3'b100, 32'h0, 1'b0, 32'h0, 5'd0, 32'h40);
    step(1'b0, 1'b0, 1'b1, 2'b00, 3'b100, 32'h0, 1'b1, 32'h0, 5'd0, 32'h40);
    // Establish non-zero MEM/WB, stall a store three cycles, release with read+write.
    step(1'b0, 1'b0, 1'b0, 2'b01, 3'b000, 32'h77, 1'b0, 32'h0, 5'd5, 32'h0);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 1'b0, 2'b11, 3'b001, 32'h8, 1'b0, 32'hA5A5_A5A5, 5'd6, 32'h0);
    step(1'b0, 1'b0, 1'b0, 2'b11, 3'b011, 32'h8, 1'b0, 32'hA5A5_A5A5, 5'd6, 32'h0);
    step(1'b0, 1'b0, 1'b0, 2'b11, 3'b010, 32'h8, 1'b0, 32'h0, 5'd7, 32'h0);
    // Flush with stall during a load.
    step(1'b0, 1'b1, 1'b1, 2'b11, 3'b010, 32'h20, 1'b0, 32'h0, 5'd8, 32'h0);

    // Random traffic over a small window of words so loads hit earlier stores.
    for (int i = 0; i < 400; i++) begin
      rm = 3'($urandom_range(0, 7));
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 11) == 0), 2'($urandom), rm,
           $urandom & 32'hFFFF_F03F, 1'($urandom), $urandom, 5'($urandom), $urandom);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
